sdram_access_arbiter: RTL and testbench
=======================================

Name: sdram_access_arbiter

Overview:
Shares the single ip_sdram instance between two requesters: port 0 is the VDP VRAM side (PRAM*) and port 1 is the MSX cartridge/CPU side (ROM/RAM mapper). The block sequences each access as one command pulse to ip_sdram. It tracks ip_sdram busy and rdata_en, and routes read data back to the requester that owns the access. Port 0 has fixed priority, with a starvation guard for port 1.

Parameters:
STARVE_LIMIT, 4, consecutive port 0 grants allowed while port 1 is pending before port 1 is forced through (1..15)
TIMEOUT, 255, cycles to wait for busy or rdata_en before the access is aborted (8-bit counter)

Ports:
clk  in  1  system clock, 108 MHz, same clock as ip_sdram
n_reset  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; level, held until p0_ack
p0_wr  in  1  port 0: 1 = write, 0 = read
p0_address  in  23  port 0 byte address
p0_wdata  in  8  port 0 write data
p0_ack  out  1  one-cycle pulse when the port 0 command is issued
p0_rdata  out  16  port 0 read data
p0_rdata_en  out  1  one-cycle pulse when p0_rdata is valid
p1_req, p1_wr, p1_address, p1_wdata, p1_ack, p1_rdata, p1_rdata_en  same as port 0, for port 1
sd_rd_n  out  1  to ip_sdram rd_n, active-low one-cycle pulse
sd_wr_n  out  1  to ip_sdram wr_n, active-low one-cycle pulse
sd_busy  in  1  from ip_sdram busy
sd_address  out  23  to ip_sdram address
sd_wdata  out  8  to ip_sdram wdata
sd_rdata  in  16  from ip_sdram rdata
sd_rdata_en  in  1  from ip_sdram rdata_en
timeout_err  out  1  one-cycle pulse when an access is aborted

Behaviour:
- Reset values (async, n_reset=0): state IDLE; sd_rd_n=1, sd_wr_n=1; sd_address=0, sd_wdata=0; all acks, rdata_en and timeout_err =0; p*_rdata=0; owner=0; starve count=0; timer=0.
- All outputs are registered.
- State IDLE:
  - Leave IDLE only when sd_busy=0 and at least one req=1.
  - Winner: port 1 if p1_req and (p0_req=0 or starve count>=STARVE_LIMIT); otherwise port 0.
  - Next edge:
    - latch address and wdata into sd_address/sd_wdata;
    - drive sd_wr_n or sd_rd_n =0 for exactly one cycle;
    - pulse the winner's p*_ack;
    - record owner and wr flag;
    - go to ISSUE.
- Starve count:
  - increments (saturating at 15) on each port 0 grant while p1_req=1;
  - clears on any port 1 grant, or on any grant while p1_req=0.
- State ISSUE (1 cycle): release the strobes, clear the timer, go to WAIT_BUSY.
- State WAIT_BUSY:
  - Write: when sd_busy=0, go to IDLE.
  - Read: when sd_rdata_en=1, copy sd_rdata to the owner's p*_rdata and pulse the owner's p*_rdata_en on the next cycle. Then go to WAIT_IDLE, or straight to IDLE if sd_busy=0 already.
  - If sd_rdata_en and sd_busy fall in the same cycle, the data is still captured.
- State WAIT_IDLE: go to IDLE when sd_busy=0.
- Timer: increments in WAIT_BUSY and WAIT_IDLE. At TIMEOUT it pulses timeout_err and forces IDLE; no rdata_en is issued for the aborted read.
- The non-owner port never sees ack or rdata_en during another port's access.
- sd_rdata_en outside WAIT_BUSY is ignored.
- Back-to-back: the minimum is 3 cycles from one ack to the next (IDLE, ISSUE, WAIT_BUSY with busy already low on a write).
- A requester that drops req before its ack has undefined behaviour. Its req is sampled only in IDLE.
- Address and data are latched at grant; requester inputs may change after ack.
- Reset mid-access returns to IDLE immediately, with the strobes deasserted asynchronously.

Optional Feature:
SDRAM_ARB_ROUND_ROBIN_EN:
- Defined: fixed priority and the starve counter are removed. The port not granted last wins whenever both request.
- Undefined: fixed port 0 priority plus the STARVE_LIMIT guard, as above.

Test Plan:
1. Single port 0 read, addr 23'h000100. Model returns busy for 6 cycles and rdata_en with 16'hA55A at cycle 5 → one p0_ack, one sd_rd_n low pulse, p0_rdata=16'hA55A with one p0_rdata_en, p1 outputs quiet.
2. p0_req and p1_req asserted together, both held continuously → grants are p0 ×4, then p1, then p0 ×4… (STARVE_LIMIT=4); p1 latency never exceeds 5 grants.
3. Port 1 write 8'h3C to 23'h7FFFFF → sd_wr_n pulses once, sd_wdata=8'h3C, sd_address=23'h7FFFFF, no rdata_en on either port.
4. Read where the model never asserts busy low or rdata_en → timeout_err pulses at cycle TIMEOUT, the arbiter returns to IDLE, and a following p0 read completes normally.
5. n_reset pulled low during WAIT_BUSY → outputs return to their reset values in the same cycle; after release there is no stale rdata_en.
6. With SDRAM_ARB_ROUND_ROBIN_EN defined and both ports requesting continuously → grants alternate p0, p1, p0, p1.

Source files
------------

// File: rtl/sdram_access_arbiter_if.sv
// Requester and ip_sdram signal bundle for sdram_access_arbiter.
// The arbiter connects through the slave modport; requesters and the SDRAM controller drive the master side.
interface sdram_access_arbiter_if;
    logic        p0_req;
    logic        p0_wr;
    logic [22:0] p0_address;
    logic [7:0]  p0_wdata;
    logic        p0_ack;
    logic [15:0] p0_rdata;
    logic        p0_rdata_en;

    logic        p1_req;
    logic        p1_wr;
    logic [22:0] p1_address;
    logic [7:0]  p1_wdata;
    logic        p1_ack;
    logic [15:0] p1_rdata;
    logic        p1_rdata_en;

    logic        sd_rd_n;
    logic        sd_wr_n;
    logic        sd_busy;
    logic [22:0] sd_address;
    logic [7:0]  sd_wdata;
    logic [15:0] sd_rdata;
    logic        sd_rdata_en;
    logic        timeout_err;

    modport slave (
        input  p0_req, p0_wr, p0_address, p0_wdata,
        output p0_ack, p0_rdata, p0_rdata_en,
        input  p1_req, p1_wr, p1_address, p1_wdata,
        output p1_ack, p1_rdata, p1_rdata_en,
        output sd_rd_n, sd_wr_n, sd_address, sd_wdata, timeout_err,
        input  sd_busy, sd_rdata, sd_rdata_en
    );

    modport master (
        output p0_req, p0_wr, p0_address, p0_wdata,
        input  p0_ack, p0_rdata, p0_rdata_en,
        output p1_req, p1_wr, p1_address, p1_wdata,
        input  p1_ack, p1_rdata, p1_rdata_en,
        input  sd_rd_n, sd_wr_n, sd_address, sd_wdata, timeout_err,
        output sd_busy, sd_rdata, sd_rdata_en
    );
endinterface

// File: rtl/sdram_access_arbiter.sv
// Two-port arbiter in front of ip_sdram: port 0 (VDP VRAM) and port 1 (cartridge/CPU), one command per access.
// Define SDRAM_ARB_ROUND_ROBIN_EN to replace fixed priority plus starvation guard with round-robin.
module sdram_access_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          n_reset,
    sdram_access_arbiter_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_IDLE
    } state_t;

    // Abort once the wait has lasted TIMEOUT cycles (timer runs 0..TIMEOUT-1).
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        sd_rd_n_q;
    logic        sd_wr_n_q;
    logic [22:0] sd_address_q;
    logic [7:0]  sd_wdata_q;
    logic        p0_ack_q;
    logic        p1_ack_q;
    logic [15:0] p0_rdata_q;
    logic [15:0] p1_rdata_q;
    logic        p0_rdata_en_q;
    logic        p1_rdata_en_q;
    logic        timeout_err_q;
    logic        owner;
    logic        wr_flag;
    logic [7:0]  timer;

    logic        grant;
    logic        win_p1;

    assign grant = (state == IDLE) && !bus.sd_busy && (bus.p0_req || bus.p1_req);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic last_p1;

    always_comb begin
        win_p1 = bus.p1_req && (!bus.p0_req || !last_p1);
    end

    // Starts as if port 1 went last so port 0 wins the first contested grant.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            last_p1 <= 1'b1;
        end else if (grant) begin
            last_p1 <= win_p1;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        win_p1 = bus.p1_req && (!bus.p0_req || (starve_cnt >= STARVE_LIM));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            starve_cnt <= 4'd0;
        end else if (grant) begin
            if (!win_p1 && bus.p1_req) begin
                starve_cnt <= sat_inc4(starve_cnt);
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state         <= IDLE;
            sd_rd_n_q     <= 1'b1;
            sd_wr_n_q     <= 1'b1;
            sd_address_q  <= 23'd0;
            sd_wdata_q    <= 8'd0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            p0_rdata_q    <= 16'd0;
            p1_rdata_q    <= 16'd0;
            p0_rdata_en_q <= 1'b0;
            p1_rdata_en_q <= 1'b0;
            timeout_err_q <= 1'b0;
            owner         <= 1'b0;
            wr_flag       <= 1'b0;
            timer         <= 8'd0;
        end else begin
            // Strobes and pulses are single-cycle unless set again below.
            sd_rd_n_q     <= 1'b1;
            sd_wr_n_q     <= 1'b1;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            p0_rdata_en_q <= 1'b0;
            p1_rdata_en_q <= 1'b0;
            timeout_err_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        owner <= win_p1;
                        state <= ISSUE;
                        if (win_p1) begin
                            sd_address_q <= bus.p1_address;
                            sd_wdata_q   <= bus.p1_wdata;
                            wr_flag      <= bus.p1_wr;
                            sd_wr_n_q    <= ~bus.p1_wr;
                            sd_rd_n_q    <= bus.p1_wr;
                            p1_ack_q     <= 1'b1;
                        end else begin
                            sd_address_q <= bus.p0_address;
                            sd_wdata_q   <= bus.p0_wdata;
                            wr_flag      <= bus.p0_wr;
                            sd_wr_n_q    <= ~bus.p0_wr;
                            sd_rd_n_q    <= bus.p0_wr;
                            p0_ack_q     <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    timer <= 8'd0;
                    state <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    // Read data wins even if busy drops in the same cycle.
                    if (!wr_flag && bus.sd_rdata_en) begin
                        if (owner) begin
                            p1_rdata_q    <= bus.sd_rdata;
                            p1_rdata_en_q <= 1'b1;
                        end else begin
                            p0_rdata_q    <= bus.sd_rdata;
                            p0_rdata_en_q <= 1'b1;
                        end
                        state <= bus.sd_busy ? WAIT_IDLE : IDLE;
                    end else if (wr_flag && !bus.sd_busy) begin
                        state <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err_q <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                WAIT_IDLE: begin
                    if (!bus.sd_busy) begin
                        state <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err_q <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sd_rd_n     = sd_rd_n_q;
    assign bus.sd_wr_n     = sd_wr_n_q;
    assign bus.sd_address  = sd_address_q;
    assign bus.sd_wdata    = sd_wdata_q;
    assign bus.p0_ack      = p0_ack_q;
    assign bus.p1_ack      = p1_ack_q;
    assign bus.p0_rdata    = p0_rdata_q;
    assign bus.p1_rdata    = p1_rdata_q;
    assign bus.p0_rdata_en = p0_rdata_en_q;
    assign bus.p1_rdata_en = p1_rdata_en_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench for sdram_access_arbiter with a small behavioural ip_sdram model.
// Expected grant order follows SDRAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_sdram_access_arbiter;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    sdram_access_arbiter_if bus ();

    sdram_access_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (255)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    // SDRAM model: busy rises the cycle after a strobe, rdata_en at m_rd_at, busy falls at m_busy_len.
    logic        m_busy  = 1'b0;
    logic        m_rden  = 1'b0;
    logic [15:0] m_rdata = 16'h0000;
    int          m_k = 0;
    bit          m_active = 1'b0;
    bit          m_isrd = 1'b0;
    bit          m_hang = 1'b0;
    int          m_rd_at = 5;
    int          m_busy_len = 6;
    logic [15:0] m_data = 16'h0000;

    assign bus.sd_busy     = m_busy;
    assign bus.sd_rdata_en = m_rden;
    assign bus.sd_rdata    = m_rdata;

    always @(negedge clk) begin
        m_rden = 1'b0;
        if (!bus.sd_rd_n || !bus.sd_wr_n) begin
            m_busy   = 1'b1;
            m_k      = 0;
            m_active = 1'b1;
            m_isrd   = !bus.sd_rd_n;
        end else if (m_active) begin
            m_k++;
            if (m_isrd && !m_hang && m_k == m_rd_at) begin
                m_rden  = 1'b1;
                m_rdata = m_data;
            end
            if (!m_hang && m_k >= m_busy_len) begin
                m_busy   = 1'b0;
                m_active = 1'b0;
            end
        end
    end

    // Pulse counters: 0 p0_ack, 1 p1_ack, 2 p0_rdata_en, 3 p1_rdata_en, 4 timeout_err, 5 rd strobe, 6 wr strobe
    int cnt [7];
    int base [7];

    initial begin
        for (int i = 0; i < 7; i++) cnt[i] = 0;
    end

    always @(negedge clk) begin
        if (n_reset) begin
            cnt[0] += int'(bus.p0_ack);
            cnt[1] += int'(bus.p1_ack);
            cnt[2] += int'(bus.p0_rdata_en);
            cnt[3] += int'(bus.p1_rdata_en);
            cnt[4] += int'(bus.timeout_err);
            cnt[5] += int'(!bus.sd_rd_n);
            cnt[6] += int'(!bus.sd_wr_n);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 7; i++) base[i] = cnt[i];
    endtask

    function automatic int delta(input int i);
        return cnt[i] - base[i];
    endfunction

    function automatic bit evt(input int sel);
        case (sel)
            0:       return bus.p0_ack;
            1:       return bus.p1_ack;
            2:       return bus.p0_rdata_en;
            3:       return bus.p1_rdata_en;
            4:       return bus.timeout_err;
            default: return bus.p0_ack | bus.p1_ack;
        endcase
    endfunction

    task automatic wait_evt(input string tag, input int sel, input int bound, output int n);
        n = 0;
        forever begin
            tick();
            n++;
            if (evt(sel)) return;
            if (n >= bound) begin
                check({tag, "_expired"}, 32'd0, 32'd1);
                n = -1;
                return;
            end
        end
    endtask

    task automatic p0_read(input logic [22:0] addr);
        bus.p0_wr      = 1'b0;
        bus.p0_address = addr;
        bus.p0_wdata   = 8'h00;
        bus.p0_req     = 1'b1;
    endtask

    bit exp_g [10];
    int n;

    initial begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        bus.p0_req = 1'b0; bus.p0_wr = 1'b0; bus.p0_address = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_wr = 1'b0; bus.p1_address = '0; bus.p1_wdata = '0;

        // Reset values
        repeat (3) tick();
        check("rst_rd_n", 32'(bus.sd_rd_n), 32'd1);
        check("rst_wr_n", 32'(bus.sd_wr_n), 32'd1);
        check("rst_addr", 32'(bus.sd_address), 32'd0);
        check("rst_wdata", 32'(bus.sd_wdata), 32'd0);
        check("rst_acks", 32'({bus.p0_ack, bus.p1_ack}), 32'd0);
        check("rst_rden", 32'({bus.p0_rdata_en, bus.p1_rdata_en, bus.timeout_err}), 32'd0);
        check("rst_rdata", 32'(bus.p0_rdata | bus.p1_rdata), 32'd0);
        n_reset = 1'b1;
        repeat (2) tick();

        // Port 0 read
        m_rd_at = 5; m_busy_len = 6; m_data = 16'hA55A;
        snap();
        p0_read(23'h000100);
        wait_evt("t1_ack", 0, 20, n);
        check("t1_rd_strobe", 32'(bus.sd_rd_n), 32'd0);
        bus.p0_req = 1'b0;
        wait_evt("t1_rden", 2, 20, n);
        check("t1_ack_to_rden", 32'(n), 32'd6);
        check("t1_rdata", 32'(bus.p0_rdata), 32'hA55A);
        repeat (10) tick();
        check("t1_p0_acks", 32'(delta(0)), 32'd1);
        check("t1_rd_pulses", 32'(delta(5)), 32'd1);
        check("t1_wr_pulses", 32'(delta(6)), 32'd0);
        check("t1_p0_rdens", 32'(delta(2)), 32'd1);
        check("t1_p1_quiet", 32'(delta(1) + delta(3)), 32'd0);
        check("t1_addr", 32'(bus.sd_address), 32'h000100);

        // Port 1 write to top address
        m_busy_len = 2;
        snap();
        bus.p1_wr = 1'b1; bus.p1_address = 23'h7FFFFF; bus.p1_wdata = 8'h3C; bus.p1_req = 1'b1;
        wait_evt("t3_ack", 1, 20, n);
        check("t3_wr_strobe", 32'(bus.sd_wr_n), 32'd0);
        check("t3_no_rd_strobe", 32'(bus.sd_rd_n), 32'd1);
        bus.p1_req = 1'b0;
        bus.p1_wdata = 8'h00; bus.p1_address = 23'h0;
        repeat (8) tick();
        check("t3_addr", 32'(bus.sd_address), 32'h7FFFFF);
        check("t3_wdata", 32'(bus.sd_wdata), 32'h3C);
        check("t3_wr_pulses", 32'(delta(6)), 32'd1);
        check("t3_no_rden", 32'(delta(2) + delta(3)), 32'd0);
        check("t3_p0_quiet", 32'(delta(0)), 32'd0);

        // Both ports requesting continuously
        bus.p0_wr = 1'b1; bus.p0_address = 23'h000010; bus.p0_wdata = 8'h11;
        bus.p1_wr = 1'b1; bus.p1_address = 23'h000020; bus.p1_wdata = 8'h22;
        bus.p0_req = 1'b1; bus.p1_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_evt("t2_ack", 5, 20, n);
            check($sformatf("t2_grant%0d_is_p1", i), 32'(bus.p1_ack), 32'(exp_g[i]));
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        repeat (8) tick();

        // Timeout on a hung read, then a normal read
        m_hang = 1'b1; m_busy_len = 6;
        snap();
        p0_read(23'h000400);
        wait_evt("t4_ack", 0, 20, n);
        bus.p0_req = 1'b0;
        wait_evt("t4_tmo", 4, 400, n);
        check("t4_ack_to_timeout", 32'(n), 32'd256);
        tick();
        check("t4_tmo_pulses", 32'(delta(4)), 32'd1);
        check("t4_no_rden", 32'(delta(2)), 32'd0);
        m_hang = 1'b0;
        repeat (3) tick();
        m_data = 16'h1234;
        snap();
        p0_read(23'h000200);
        wait_evt("t4b_ack", 0, 20, n);
        bus.p0_req = 1'b0;
        wait_evt("t4b_rden", 2, 20, n);
        check("t4b_rdata", 32'(bus.p0_rdata), 32'h1234);
        repeat (8) tick();
        check("t4b_rdens", 32'(delta(2)), 32'd1);
        check("t4b_no_tmo", 32'(delta(4)), 32'd0);

        // Reset during WAIT_BUSY
        m_data = 16'h5678;
        p0_read(23'h000300);
        wait_evt("t5_ack", 0, 20, n);
        bus.p0_req = 1'b0;
        repeat (2) tick();
        n_reset = 1'b0;
        #1;
        check("t5_addr_rst", 32'(bus.sd_address), 32'd0);
        check("t5_rdata_rst", 32'(bus.p0_rdata), 32'd0);
        check("t5_rd_n_rst", 32'(bus.sd_rd_n), 32'd1);
        tick();
        n_reset = 1'b1;
        snap();
        repeat (10) tick();
        check("t5_no_stale_rden", 32'(delta(2) + delta(3)), 32'd0);
        check("t5_rdata_still0", 32'(bus.p0_rdata), 32'd0);

        // Port 1 read routes data only to port 1
        m_data = 16'hBEEF;
        snap();
        bus.p1_wr = 1'b0; bus.p1_address = 23'h001000; bus.p1_req = 1'b1;
        wait_evt("t6_ack", 1, 20, n);
        bus.p1_req = 1'b0;
        wait_evt("t6_rden", 3, 20, n);
        check("t6_rdata", 32'(bus.p1_rdata), 32'hBEEF);
        repeat (8) tick();
        check("t6_p1_rdens", 32'(delta(3)), 32'd1);
        check("t6_p0_quiet", 32'(delta(0) + delta(2)), 32'd0);
        check("t6_p0_rdata_kept", 32'(bus.p0_rdata), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
